c7b_biu_arb: RTL
================

C7B_BIU_ARB -- requirements
Module: c7b_biu_arb
Interface
REQ-001 SHALL have parameter IFU_STARVE_MAX, default 4, max consecutive LSU grants while ifu_biu_rd_req pending.
REQ-002 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port resetn  in  1  reset, synchronous active-low.
REQ-004 SHALL have port ifu_biu_rd_req  in  1  IFU read request, held until ack.
REQ-005 SHALL have port ifu_biu_rd_addr  in  32  IFU read address, stable while req.
REQ-006 SHALL have port biu_ifu_rd_ack  out  1  IFU request accepted, one-cycle pulse.
REQ-007 SHALL have port biu_ifu_data_valid  out  1  IFU read data valid, one-cycle pulse.
REQ-008 SHALL have port biu_ifu_data  out  64  IFU read data.
REQ-009 SHALL have port lsu_biu_rd_req  in  1  LSU read request, held until ack.
REQ-010 SHALL have port lsu_biu_rd_addr  in  32  LSU read address.
REQ-011 SHALL have port biu_lsu_rd_ack  out  1  LSU read accepted pulse.
REQ-012 SHALL have port biu_lsu_data_valid  out  1  LSU read data valid pulse.
REQ-013 SHALL have port biu_lsu_data  out  64  LSU read data.
REQ-014 SHALL have port lsu_biu_wr_req  in  1  LSU write request, held until ack.
REQ-015 SHALL have port lsu_biu_wr_addr  in  32  LSU write address.
REQ-016 SHALL have port lsu_biu_wr_data  in  64  LSU write data.
REQ-017 SHALL have port lsu_biu_wr_strb  in  8  LSU byte strobes.
REQ-018 SHALL have port biu_lsu_wr_ack  out  1  LSU write accepted pulse.
REQ-019 SHALL have port biu_lsu_write_done  out  1  LSU write complete pulse.
REQ-020 SHALL have port biu_mem_req  out  1  memory request, held until mem_biu_ack.
REQ-021 SHALL have port biu_mem_we  out  1  1 = write, 0 = read.
REQ-022 SHALL have port biu_mem_addr  out  32  latched request address.
REQ-023 SHALL have port biu_mem_wdata  out  64  latched write data.
REQ-024 SHALL have port biu_mem_wstrb  out  8  latched strobes; 0 on reads.
REQ-025 SHALL have port mem_biu_ack  in  1  memory accepted biu_mem_req.
REQ-026 SHALL have port mem_biu_rvalid  in  1  memory read data valid.
REQ-027 SHALL have port mem_biu_rdata  in  64  memory read data.
REQ-028 SHALL have port mem_biu_wdone  in  1  memory write complete.
Function
REQ-029 SHALL implement FSM IDLE, REQ, WAIT_RD, WAIT_WR; one outstanding single-beat transaction.
REQ-030 IDLE with any request pending SHALL grant, latch owner/addr/data/strb, go REQ next cycle; no pending stays IDLE.
REQ-031 Priority SHALL be lsu_wr > lsu_rd > ifu_rd, except starve counter == IFU_STARVE_MAX and ifu pending grants IFU.
REQ-032 Starve counter SHALL increment on each LSU grant while ifu_biu_rd_req high, clear on IFU grant or ifu req low, saturate at IFU_STARVE_MAX.
REQ-033 REQ SHALL drive biu_mem_req=1; in cycle mem_biu_ack=1 owner's ack SHALL pulse combinationally and FSM goes WAIT_RD (read) or WAIT_WR (write).
REQ-034 WAIT_RD on mem_biu_rvalid SHALL pulse owner's data_valid with mem_biu_rdata same cycle, go IDLE; non-owner valid stays 0.
REQ-035 WAIT_WR on mem_biu_wdone SHALL pulse biu_lsu_write_done same cycle, go IDLE.
REQ-036 Minimum SHALL be: grant cycle, REQ+ack cycle, response cycle; next grant earliest cycle after response (no back-to-back bypass).
REQ-037 rvalid/wdone outside WAIT_RD/WAIT_WR respectively SHALL be ignored; acks never pulse outside REQ.
REQ-038 Requests changing during REQ/WAIT_* SHALL not affect the latched transaction; arbitration re-evaluates only in IDLE.
REQ-039 biu_ifu_data and biu_lsu_data SHALL be 0 when their data_valid is 0.
Reset
REQ-040 resetn low at clk edge SHALL force IDLE, counter 0, all outputs 0 next cycle, even mid-transaction; stale responses after reset ignored per REQ-037.
REQ-041 Latched addr/data/strb SHALL reset to 0.
Structure
REQ-042 Package c7b_biu_pkg SHALL hold FSM state encoding, owner encoding (OWN_IFU, OWN_LSU_RD, OWN_LSU_WR), IFU_STARVE_MAX default.
REQ-043 Priority/starvation select SHALL be sub-module c7b_biu_prio_sel (combinational grant from requests and counter).
Verification
REQ-044 IFU read 0x1C000000, ack after 2 cycles, rvalid with 0x0123456789ABCDEF -> one biu_ifu_rd_ack, biu_ifu_data_valid with that data, LSU outputs 0.
REQ-045 lsu_wr, lsu_rd, ifu_rd asserted same cycle -> grant order write, LSU read, IFU; write_done before LSU ack.
REQ-046 Continuous LSU reads plus IFU pending, IFU_STARVE_MAX=4 -> IFU granted after exactly 4 LSU grants.
REQ-047 LSU write strb 0x0F, addr 0x80 -> biu_mem_we=1, wstrb=0x0F, addr 0x80 held until ack; write_done pulses on mem_biu_wdone.
REQ-048 resetn low in WAIT_RD, then rvalid after reset -> FSM IDLE, no data_valid pulse, all outputs 0.

Source files
------------

// File: rtl/c7b_biu_pkg.sv
// Shared types and defaults for the c7b bus interface unit read/write arbiter.
package c7b_biu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_WAIT_RD = 2'd2,
    ST_WAIT_WR = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    OWN_IFU    = 2'd0,
    OWN_LSU_RD = 2'd1,
    OWN_LSU_WR = 2'd2
  } owner_e;

  localparam int IFU_STARVE_MAX_DEF = 4;

  // Counter width that always holds 0..max_cnt and is never zero bits wide.
  function automatic int starve_cw(input int max_cnt);
    return $clog2(max_cnt + 2);
  endfunction

endpackage

// File: rtl/c7b_biu_prio_sel.sv
// Combinational grant select: lsu write > lsu read > ifu read, with the IFU
// forced through once the starvation counter has reached its limit.
module c7b_biu_prio_sel
  import c7b_biu_pkg::*;
#(
  parameter int IFU_STARVE_MAX = IFU_STARVE_MAX_DEF,
  parameter int CW             = starve_cw(IFU_STARVE_MAX)
) (
  input  logic          ifu_rd_req,
  input  logic          lsu_rd_req,
  input  logic          lsu_wr_req,
  input  logic [CW-1:0] starve_cnt,
  output logic          grant_vld,
  output logic [1:0]    grant_own
);

  localparam logic [CW-1:0] STARVE_LIM = CW'(IFU_STARVE_MAX);

  always_comb begin
    grant_vld = ifu_rd_req | lsu_rd_req | lsu_wr_req;
    grant_own = OWN_IFU;
    if (ifu_rd_req && (starve_cnt == STARVE_LIM)) begin
      grant_own = OWN_IFU;
    end else if (lsu_wr_req) begin
      grant_own = OWN_LSU_WR;
    end else if (lsu_rd_req) begin
      grant_own = OWN_LSU_RD;
    end
  end

endmodule

// File: rtl/c7b_biu_arb.sv
// Single-outstanding BIU arbiter: grants one of IFU read / LSU read / LSU write
// in IDLE, presents it to memory until accepted, then waits for its response.
module c7b_biu_arb
  import c7b_biu_pkg::*;
#(
  parameter int IFU_STARVE_MAX = IFU_STARVE_MAX_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ifu_biu_rd_req,
  input  logic [31:0] ifu_biu_rd_addr,
  output logic        biu_ifu_rd_ack,
  output logic        biu_ifu_data_valid,
  output logic [63:0] biu_ifu_data,
  input  logic        lsu_biu_rd_req,
  input  logic [31:0] lsu_biu_rd_addr,
  output logic        biu_lsu_rd_ack,
  output logic        biu_lsu_data_valid,
  output logic [63:0] biu_lsu_data,
  input  logic        lsu_biu_wr_req,
  input  logic [31:0] lsu_biu_wr_addr,
  input  logic [63:0] lsu_biu_wr_data,
  input  logic [7:0]  lsu_biu_wr_strb,
  output logic        biu_lsu_wr_ack,
  output logic        biu_lsu_write_done,
  output logic        biu_mem_req,
  output logic        biu_mem_we,
  output logic [31:0] biu_mem_addr,
  output logic [63:0] biu_mem_wdata,
  output logic [7:0]  biu_mem_wstrb,
  input  logic        mem_biu_ack,
  input  logic        mem_biu_rvalid,
  input  logic [63:0] mem_biu_rdata,
  input  logic        mem_biu_wdone
);

  localparam int            CW         = starve_cw(IFU_STARVE_MAX);
  localparam logic [CW-1:0] STARVE_LIM = CW'(IFU_STARVE_MAX);

  state_e        r_state;
  state_e        w_state_nxt;
  owner_e        r_owner;
  logic [31:0]   r_addr;
  logic [63:0]   r_wdata;
  logic [7:0]    r_wstrb;
  logic [CW-1:0] r_starve_cnt;
  logic          w_grant_vld;
  logic [1:0]    w_grant_own;
  logic          w_grant;

  c7b_biu_prio_sel #(
    .IFU_STARVE_MAX (IFU_STARVE_MAX),
    .CW             (CW)
  ) u_prio_sel (
    .ifu_rd_req (ifu_biu_rd_req),
    .lsu_rd_req (lsu_biu_rd_req),
    .lsu_wr_req (lsu_biu_wr_req),
    .starve_cnt (r_starve_cnt),
    .grant_vld  (w_grant_vld),
    .grant_own  (w_grant_own)
  );

  assign w_grant = (r_state == ST_IDLE) && w_grant_vld;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Transaction fields are captured only at grant so later request changes are ignored.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_owner      <= OWN_IFU;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_starve_cnt <= '0;
    end else begin
      if (w_grant) begin
        r_owner <= owner_e'(w_grant_own);
        r_wdata <= '0;
        r_wstrb <= '0;
        if (w_grant_own == OWN_LSU_WR) begin
          r_addr  <= lsu_biu_wr_addr;
          r_wdata <= lsu_biu_wr_data;
          r_wstrb <= lsu_biu_wr_strb;
        end else if (w_grant_own == OWN_LSU_RD) begin
          r_addr <= lsu_biu_rd_addr;
        end else begin
          r_addr <= ifu_biu_rd_addr;
        end
      end
      if (!ifu_biu_rd_req) begin
        r_starve_cnt <= '0;
      end else if (w_grant) begin
        if (w_grant_own == OWN_IFU) begin
          r_starve_cnt <= '0;
        end else if (r_starve_cnt != STARVE_LIM) begin
          r_starve_cnt <= r_starve_cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_state_nxt        = r_state;
    biu_mem_req        = 1'b0;
    biu_mem_we         = 1'b0;
    biu_mem_addr       = '0;
    biu_mem_wdata      = '0;
    biu_mem_wstrb      = '0;
    biu_ifu_rd_ack     = 1'b0;
    biu_lsu_rd_ack     = 1'b0;
    biu_lsu_wr_ack     = 1'b0;
    biu_ifu_data_valid = 1'b0;
    biu_ifu_data       = '0;
    biu_lsu_data_valid = 1'b0;
    biu_lsu_data       = '0;
    biu_lsu_write_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_vld) w_state_nxt = ST_REQ;
      end
      ST_REQ: begin
        biu_mem_req   = 1'b1;
        biu_mem_we    = (r_owner == OWN_LSU_WR);
        biu_mem_addr  = r_addr;
        biu_mem_wdata = r_wdata;
        biu_mem_wstrb = r_wstrb;
        if (mem_biu_ack) begin
          if (r_owner == OWN_LSU_WR) begin
            biu_lsu_wr_ack = 1'b1;
            w_state_nxt    = ST_WAIT_WR;
          end else if (r_owner == OWN_LSU_RD) begin
            biu_lsu_rd_ack = 1'b1;
            w_state_nxt    = ST_WAIT_RD;
          end else begin
            biu_ifu_rd_ack = 1'b1;
            w_state_nxt    = ST_WAIT_RD;
          end
        end
      end
      ST_WAIT_RD: begin
        if (mem_biu_rvalid) begin
          if (r_owner == OWN_IFU) begin
            biu_ifu_data_valid = 1'b1;
            biu_ifu_data       = mem_biu_rdata;
          end else begin
            biu_lsu_data_valid = 1'b1;
            biu_lsu_data       = mem_biu_rdata;
          end
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT_WR: begin
        if (mem_biu_wdone) begin
          biu_lsu_write_done = 1'b1;
          w_state_nxt        = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule
